// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sap_pkg
//  Purpose  : Shared types and constants for the SAP control sequencer:
//             opcode encoding, one-hot T-state constants, control word.
//  Revision : 1.0  initial release
// ============================================================================
package sap_pkg;

  localparam int TS_W = 6;

  typedef enum logic [3:0] {
    LDA = 4'h0,
    ADD = 4'h1,
    SUB = 4'h2,
    LDI = 4'h3,
    JMP = 4'h4,
    JC  = 4'h5,
    OUT = 4'hE,
    HLT = 4'hF
  } opcode_t;

  typedef logic [TS_W-1:0] tstate_t;

  localparam tstate_t T1 = 6'b000001;
  localparam tstate_t T2 = 6'b000010;
  localparam tstate_t T3 = 6'b000100;
  localparam tstate_t T4 = 6'b001000;
  localparam tstate_t T5 = 6'b010000;
  localparam tstate_t T6 = 6'b100000;

  // The 13 datapath control bits; hlt is carried separately because it
  // also survives into the HALTED state where everything else is cleared.
  typedef struct packed {
    logic pc_en;
    logic pc_oe;
    logic pc_load;
    logic mar_load;
    logic ram_oe;
    logic ir_load;
    logic ir_oe;
    logic a_load;
    logic a_oe;
    logic b_load;
    logic sub;
    logic alu_oe;
    logic out_load;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  // True for the two instructions that update the carry flag at end of T6.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tstate_ring.sv
`default_nettype none
// ============================================================================
//  Module   : tstate_ring
//  Purpose  : One-hot ring counter T1->...->TN->T1 with synchronous reset
//             to T1 and a freeze input that holds the current state.
//  Revision : 1.0  initial release
// ============================================================================
module tstate_ring
  import sap_pkg::*;
#(
  parameter int N = TS_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         freeze_i,
  output logic [N-1:0] state_o
);

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;

  // Rotate the single hot bit one position per clock unless frozen.
  always_comb begin
    state_d = state_q;
    if (!freeze_i) begin
      state_d = {state_q[N-2:0], state_q[N-1]};
    end
  end

  // State register; reset places the token on the first T-state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= {{(N-1){1'b0}}, 1'b1};
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/sap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sap_controller
//  Purpose  : SAP-1 control sequencer. Runs the 6-clock fetch/execute ring,
//             decodes the opcode into the control word, owns the carry flag
//             and the terminal HALTED state.
//  Revision : 1.0  initial release
// ============================================================================
module sap_controller
  import sap_pkg::*;
#(
  parameter int T_STATES = 6
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [3:0]          opcode,
  input  logic                c_in,
  output logic                pc_en,
  output logic                pc_oe,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_oe,
  output logic                ir_load,
  output logic                ir_oe,
  output logic                a_load,
  output logic                a_oe,
  output logic                b_load,
  output logic                sub,
  output logic                alu_oe,
  output logic                out_load,
  output logic                hlt,
  output logic                carry_flag,
  output logic [T_STATES-1:0] tstate
);

  logic [T_STATES-1:0] state;
  logic                halted_q;
  logic                halted_d;
  logic                carry_q;
  logic                carry_d;
  logic                hlt_now;
  logic                freeze;
  ctrl_word_t          ctrl;
  logic                hlt_bit;

  // HLT is recognised in T4; from the following edge the machine sits in
  // HALTED with the ring frozen so it can never wander into another fetch.
  assign hlt_now = !halted_q && (state == T4) && (opcode == HLT);
  assign freeze  = halted_q || hlt_now;

  tstate_ring #(
    .N (T_STATES)
  ) u_ring (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .freeze_i (freeze),
    .state_o  (state)
  );

  // Next-state for the halt latch and the carry flag.
  always_comb begin
    halted_d = halted_q || hlt_now;
    carry_d  = carry_q;
    if (!halted_q && (state == T6) && is_alu_op(opcode)) begin
      carry_d = c_in;
    end
  end

  // Halt and carry registers, cleared by synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      halted_q <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      halted_q <= halted_d;
      carry_q  <= carry_d;
    end
  end

  // Control word decode from (state, opcode, carry); reset forces all zero.
  always_comb begin
    ctrl    = CTRL_NOP;
    hlt_bit = 1'b0;
    if (RESET) begin
      ctrl    = CTRL_NOP;
      hlt_bit = 1'b0;
    end else if (halted_q) begin
      hlt_bit = 1'b1;
    end else begin
      case (state)
        T1: begin
          ctrl.pc_oe    = 1'b1;
          ctrl.mar_load = 1'b1;
        end
        T2: begin
          ctrl.pc_en = 1'b1;
        end
        T3: begin
          ctrl.ram_oe  = 1'b1;
          ctrl.ir_load = 1'b1;
        end
        T4: begin
          case (opcode)
            LDA, ADD, SUB: begin
              ctrl.ir_oe    = 1'b1;
              ctrl.mar_load = 1'b1;
            end
            LDI: begin
              ctrl.ir_oe  = 1'b1;
              ctrl.a_load = 1'b1;
            end
            JMP: begin
              ctrl.ir_oe   = 1'b1;
              ctrl.pc_load = 1'b1;
            end
            JC: begin
              ctrl.ir_oe   = carry_q;
              ctrl.pc_load = carry_q;
            end
            OUT: begin
              ctrl.a_oe     = 1'b1;
              ctrl.out_load = 1'b1;
            end
            HLT: begin
              hlt_bit = 1'b1;
            end
            default: ctrl = CTRL_NOP;
          endcase
        end
        T5: begin
          case (opcode)
            LDA: begin
              ctrl.ram_oe = 1'b1;
              ctrl.a_load = 1'b1;
            end
            ADD, SUB: begin
              ctrl.ram_oe = 1'b1;
              ctrl.b_load = 1'b1;
            end
            default: ctrl = CTRL_NOP;
          endcase
        end
        T6: begin
          if (is_alu_op(opcode)) begin
            ctrl.alu_oe = 1'b1;
            ctrl.a_load = 1'b1;
            ctrl.sub    = (opcode == SUB);
          end
        end
        default: ctrl = CTRL_NOP;
      endcase
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign pc_oe      = ctrl.pc_oe;
  assign pc_load    = ctrl.pc_load;
  assign mar_load   = ctrl.mar_load;
  assign ram_oe     = ctrl.ram_oe;
  assign ir_load    = ctrl.ir_load;
  assign ir_oe      = ctrl.ir_oe;
  assign a_load     = ctrl.a_load;
  assign a_oe       = ctrl.a_oe;
  assign b_load     = ctrl.b_load;
  assign sub        = ctrl.sub;
  assign alu_oe     = ctrl.alu_oe;
  assign out_load   = ctrl.out_load;
  assign hlt        = hlt_bit;
  assign carry_flag = carry_q;
  assign tstate     = state;

endmodule
`default_nettype wire

// File: tb/tb_sap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sap_controller
//  Purpose  : Directed vector table plus hand-written sequences for the
//             SAP control sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sap_controller;

  // Control-word bit positions, order {pc_en,pc_oe,pc_load,mar_load,ram_oe,
  // ir_load,ir_oe,a_load,a_oe,b_load,sub,alu_oe,out_load,hlt}.
  localparam logic [13:0] CP = 14'h2000;
  localparam logic [13:0] EP = 14'h1000;
  localparam logic [13:0] LJ = 14'h0800;
  localparam logic [13:0] LM = 14'h0400;
  localparam logic [13:0] CE = 14'h0200;
  localparam logic [13:0] LI = 14'h0100;
  localparam logic [13:0] EI = 14'h0080;
  localparam logic [13:0] LA = 14'h0040;
  localparam logic [13:0] EA = 14'h0020;
  localparam logic [13:0] LB = 14'h0010;
  localparam logic [13:0] SU = 14'h0008;
  localparam logic [13:0] EU = 14'h0004;
  localparam logic [13:0] LO = 14'h0002;
  localparam logic [13:0] HL = 14'h0001;
  localparam logic [13:0] NONE = 14'h0000;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        cin;
    logic [13:0] ctrl;
    logic [5:0]  ts;
    logic        carry;
  } vec_t;

  logic       CLK;
  logic       RESET;
  logic [3:0] opcode;
  logic       c_in;
  logic pc_en, pc_oe, pc_load, mar_load, ram_oe, ir_load, ir_oe;
  logic a_load, a_oe, b_load, sub, alu_oe, out_load, hlt, carry_flag;
  logic [5:0] tstate;

  int n_cmp;
  int n_bad;
  vec_t vq[$];

  sap_controller #(.T_STATES(6)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .opcode     (opcode),
    .c_in       (c_in),
    .pc_en      (pc_en),
    .pc_oe      (pc_oe),
    .pc_load    (pc_load),
    .mar_load   (mar_load),
    .ram_oe     (ram_oe),
    .ir_load    (ir_load),
    .ir_oe      (ir_oe),
    .a_load     (a_load),
    .a_oe       (a_oe),
    .b_load     (b_load),
    .sub        (sub),
    .alu_oe     (alu_oe),
    .out_load   (out_load),
    .hlt        (hlt),
    .carry_flag (carry_flag),
    .tstate     (tstate)
  );

  always #5 CLK = ~CLK;

  function automatic logic [13:0] act_ctrl();
    return {pc_en, pc_oe, pc_load, mar_load, ram_oe, ir_load, ir_oe,
            a_load, a_oe, b_load, sub, alu_oe, out_load, hlt};
  endfunction

  task automatic add(input logic r, input logic [3:0] op, input logic cin,
                     input logic [13:0] c, input logic [5:0] ts, input logic cy);
    vec_t v;
    v.rst = r; v.op = op; v.cin = cin; v.ctrl = c; v.ts = ts; v.carry = cy;
    vq.push_back(v);
  endtask

  // Fetch rows; the opcode presented here must have no effect.
  task automatic add_fetch(input logic [3:0] noise, input logic cy);
    add(1'b0, noise, 1'b1, EP | LM, S1, cy);
    add(1'b0, noise, 1'b0, CP,      S2, cy);
    add(1'b0, noise, 1'b1, CE | LI, S3, cy);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic [3:0] op, input logic cin);
    @(negedge CLK);
    RESET  = r;
    opcode = op;
    c_in   = cin;
    #1;
  endtask

  task automatic check(input string name, input logic [13:0] ec,
                       input logic [5:0] ets, input logic ecy);
    n_cmp++;
    if (act_ctrl() !== ec) begin
      n_bad++;
      $display("FAIL %s ctrl: got %014b expected %014b", name, act_ctrl(), ec);
    end
    n_cmp++;
    if (tstate !== ets) begin
      n_bad++;
      $display("FAIL %s tstate: got %06b expected %06b", name, tstate, ets);
    end
    n_cmp++;
    if (carry_flag !== ecy) begin
      n_bad++;
      $display("FAIL %s carry: got %0b expected %0b", name, carry_flag, ecy);
    end
  endtask

  initial begin
    int drivers;
    n_cmp  = 0;
    n_bad  = 0;
    CLK    = 1'b0;
    RESET  = 1'b1;
    opcode = 4'h0;
    c_in   = 1'b0;
    repeat (2) @(posedge CLK);

    // ---------------- vector table ----------------
    add(1'b1, 4'h0, 1'b0, NONE, S1, 1'b0);
    // ADD, carry in 1
    add_fetch(4'hF, 1'b0);
    add(1'b0, 4'h1, 1'b0, EI | LM, S4, 1'b0);
    add(1'b0, 4'h1, 1'b0, CE | LB, S5, 1'b0);
    add(1'b0, 4'h1, 1'b1, EU | LA, S6, 1'b0);
    // SUB, carry in 0
    add_fetch(4'h0, 1'b1);
    add(1'b0, 4'h2, 1'b1, EI | LM, S4, 1'b1);
    add(1'b0, 4'h2, 1'b1, CE | LB, S5, 1'b1);
    add(1'b0, 4'h2, 1'b0, EU | LA | SU, S6, 1'b1);
    // JC with carry 0: nothing for the whole execute phase
    add_fetch(4'h5, 1'b0);
    add(1'b0, 4'h5, 1'b1, NONE, S4, 1'b0);
    add(1'b0, 4'h5, 1'b1, NONE, S5, 1'b0);
    add(1'b0, 4'h5, 1'b1, NONE, S6, 1'b0);
    // LDI
    add_fetch(4'h3, 1'b0);
    add(1'b0, 4'h3, 1'b1, EI | LA, S4, 1'b0);
    add(1'b0, 4'h3, 1'b1, NONE, S5, 1'b0);
    add(1'b0, 4'h3, 1'b1, NONE, S6, 1'b0);
    // ADD, carry in 1 again
    add_fetch(4'h1, 1'b0);
    add(1'b0, 4'h1, 1'b0, EI | LM, S4, 1'b0);
    add(1'b0, 4'h1, 1'b0, CE | LB, S5, 1'b0);
    add(1'b0, 4'h1, 1'b1, EU | LA, S6, 1'b0);
    // JC with carry 1
    add_fetch(4'h7, 1'b1);
    add(1'b0, 4'h5, 1'b0, EI | LJ, S4, 1'b1);
    add(1'b0, 4'h5, 1'b0, NONE, S5, 1'b1);
    add(1'b0, 4'h5, 1'b0, NONE, S6, 1'b1);
    // JMP (HLT opcode during fetch is ignored)
    add_fetch(4'hF, 1'b1);
    add(1'b0, 4'h4, 1'b0, EI | LJ, S4, 1'b1);
    add(1'b0, 4'h4, 1'b0, NONE, S5, 1'b1);
    add(1'b0, 4'h4, 1'b0, NONE, S6, 1'b1);
    // OUT
    add_fetch(4'hE, 1'b1);
    add(1'b0, 4'hE, 1'b0, EA | LO, S4, 1'b1);
    add(1'b0, 4'hE, 1'b0, NONE, S5, 1'b1);
    add(1'b0, 4'hE, 1'b0, NONE, S6, 1'b1);
    // NOP 0x9
    add_fetch(4'h2, 1'b1);
    add(1'b0, 4'h9, 1'b0, NONE, S4, 1'b1);
    add(1'b0, 4'h9, 1'b0, NONE, S5, 1'b1);
    add(1'b0, 4'h9, 1'b0, NONE, S6, 1'b1);
    // LDA; carry must hold through its T6
    add_fetch(4'h0, 1'b1);
    add(1'b0, 4'h0, 1'b0, EI | LM, S4, 1'b1);
    add(1'b0, 4'h0, 1'b0, CE | LA, S5, 1'b1);
    add(1'b0, 4'h0, 1'b0, NONE, S6, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].op, vq[i].cin);
      check($sformatf("vec%0d", i), vq[i].ctrl, vq[i].ts, vq[i].carry);
    end

    // ---------------- HLT and halted hold ----------------
    drive(1'b0, 4'h0, 1'b0); check("hlt_t1", EP | LM, S1, 1'b1);
    drive(1'b0, 4'h0, 1'b0); check("hlt_t2", CP, S2, 1'b1);
    drive(1'b0, 4'h0, 1'b0); check("hlt_t3", CE | LI, S3, 1'b1);
    drive(1'b0, 4'hF, 1'b0); check("hlt_t4", HL, S4, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      check($sformatf("halted%0d", i), HL, S4, 1'b1);
    end
    // First reset cycle: outputs forced off, registers not yet cleared.
    drive(1'b1, 4'h0, 1'b0); check("halt_rst_a", NONE, S4, 1'b1);
    drive(1'b1, 4'h0, 1'b0); check("halt_rst_b", NONE, S1, 1'b0);
    drive(1'b0, 4'h0, 1'b0); check("post_halt_t1", EP | LM, S1, 1'b0);

    // ---------------- reset during LDA T5 ----------------
    drive(1'b0, 4'h0, 1'b0); check("lda_t2", CP, S2, 1'b0);
    drive(1'b0, 4'h0, 1'b0); check("lda_t3", CE | LI, S3, 1'b0);
    drive(1'b0, 4'h0, 1'b0); check("lda_t4", EI | LM, S4, 1'b0);
    drive(1'b1, 4'h0, 1'b0); check("lda_t5_rst", NONE, S5, 1'b0);
    drive(1'b1, 4'h0, 1'b0); check("lda_rst_hold", NONE, S1, 1'b0);
    drive(1'b0, 4'h0, 1'b0); check("lda_rst_t1", EP | LM, S1, 1'b0);

    // ---------------- random opcodes: bus-driver invariant ----------------
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)));
      drivers = int'(pc_oe) + int'(ram_oe) + int'(ir_oe) + int'(a_oe) + int'(alu_oe);
      n_cmp++;
      if (drivers > 1 || hlt !== 1'b0) begin
        n_bad++;
        $display("FAIL bus_rand%0d: got %0d drivers hlt=%0b required <=1 drivers hlt=0",
                 i, drivers, hlt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
